// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and data access.
// One outstanding access at a time, registered request/response paths and a per-access timeout.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no access in flight; arbitrate between pending requests
// INS_ACC  | fetch access presented on the memory port
// DATA_ACC | data access presented on the memory port
// RESP     | one-cycle ready strobe to the port that owned the access
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            ins_valid_in,
    input  logic [XLEN-1:0] ins_addr_in,
    output logic            ins_ready_out,
    output logic [XLEN-1:0] ins_data_out,
    output logic            ins_err_out,
    input  logic            data_valid_in,
    input  logic            data_write_in,
    input  logic [XLEN-1:0] data_addr_in,
    input  logic [XLEN-1:0] data_wdata_in,
    output logic            data_ready_out,
    output logic [XLEN-1:0] data_rdata_out,
    output logic            data_err_out,
    output logic            mem_valid_out,
    output logic            mem_write_out,
    output logic [XLEN-1:0] mem_addr_out,
    output logic [XLEN-1:0] mem_wdata_out,
    input  logic            mem_ready_in,
    input  logic [XLEN-1:0] mem_rdata_in
);

    typedef enum logic [1:0] {IDLE, INS_ACC, DATA_ACC, RESP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic            last_grant_data;
    logic [TO_W-1:0] to_cnt;
    logic            grant_ins;
    logic            grant_data;
    logic            acc_done;
    logic [XLEN-1:0] resp_data;

    // On contention the port that was not served last wins.
    always_comb begin
        grant_ins  = ins_valid_in && (!data_valid_in || last_grant_data);
        grant_data = data_valid_in && (!ins_valid_in || !last_grant_data);
        acc_done   = mem_ready_in || (to_cnt == TO_LAST);
        resp_data  = mem_ready_in ? mem_rdata_in : '0;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state           <= IDLE;
            last_grant_data <= 1'b1;
            to_cnt          <= '0;
            mem_valid_out   <= 1'b0;
            mem_write_out   <= 1'b0;
            mem_addr_out    <= '0;
            mem_wdata_out   <= '0;
            ins_ready_out   <= 1'b0;
            ins_data_out    <= '0;
            ins_err_out     <= 1'b0;
            data_ready_out  <= 1'b0;
            data_rdata_out  <= '0;
            data_err_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ins) begin
                        state           <= INS_ACC;
                        last_grant_data <= 1'b0;
                        to_cnt          <= '0;
                        mem_valid_out   <= 1'b1;
                        mem_write_out   <= 1'b0;
                        mem_addr_out    <= ins_addr_in;
                        mem_wdata_out   <= '0;
                    end else if (grant_data) begin
                        state           <= DATA_ACC;
                        last_grant_data <= 1'b1;
                        to_cnt          <= '0;
                        mem_valid_out   <= 1'b1;
                        mem_write_out   <= data_write_in;
                        mem_addr_out    <= data_addr_in;
                        mem_wdata_out   <= data_wdata_in;
                    end
                end
                INS_ACC, DATA_ACC: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (acc_done) begin
                        state         <= RESP;
                        mem_valid_out <= 1'b0;
                        if (state == INS_ACC) begin
                            ins_ready_out <= 1'b1;
                            ins_data_out  <= resp_data;
                            ins_err_out   <= !mem_ready_in;
                        end else begin
                            data_ready_out <= 1'b1;
                            data_rdata_out <= resp_data;
                            data_err_out   <= !mem_ready_in;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    ins_ready_out  <= 1'b0;
                    ins_err_out    <= 1'b0;
                    data_ready_out <= 1'b0;
                    data_err_out   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for single accesses and stray strobes,
// hand-written sequences for contention, timeout and mid-access reset.
module tb_mem_port_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic            clock_in;
    logic            reset_in;
    logic            ins_valid_in;
    logic [XLEN-1:0] ins_addr_in;
    logic            ins_ready_out;
    logic [XLEN-1:0] ins_data_out;
    logic            ins_err_out;
    logic            data_valid_in;
    logic            data_write_in;
    logic [XLEN-1:0] data_addr_in;
    logic [XLEN-1:0] data_wdata_in;
    logic            data_ready_out;
    logic [XLEN-1:0] data_rdata_out;
    logic            data_err_out;
    logic            mem_valid_out;
    logic            mem_write_out;
    logic [XLEN-1:0] mem_addr_out;
    logic [XLEN-1:0] mem_wdata_out;
    logic            mem_ready_in;
    logic [XLEN-1:0] mem_rdata_in;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .ins_valid_in   (ins_valid_in),
        .ins_addr_in    (ins_addr_in),
        .ins_ready_out  (ins_ready_out),
        .ins_data_out   (ins_data_out),
        .ins_err_out    (ins_err_out),
        .data_valid_in  (data_valid_in),
        .data_write_in  (data_write_in),
        .data_addr_in   (data_addr_in),
        .data_wdata_in  (data_wdata_in),
        .data_ready_out (data_ready_out),
        .data_rdata_out (data_rdata_out),
        .data_err_out   (data_err_out),
        .mem_valid_out  (mem_valid_out),
        .mem_write_out  (mem_write_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_ready_in   (mem_ready_in),
        .mem_rdata_in   (mem_rdata_in)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Inputs applied before an edge, expected outputs observed just after that edge.
    typedef struct {
        logic        rst, iv, dv, dw, mr;
        logic [31:0] ia, da, dwd, mrd;
        logic        x_mv, x_mw, x_ir, x_ie, x_dr, x_de;
        logic [31:0] x_ma, x_mwd, x_id, x_drd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " mem_valid"},  32'(mem_valid_out),  32'(e.x_mv));
        chk({tag, " mem_write"},  32'(mem_write_out),  32'(e.x_mw));
        chk({tag, " mem_addr"},   mem_addr_out,        e.x_ma);
        chk({tag, " mem_wdata"},  mem_wdata_out,       e.x_mwd);
        chk({tag, " ins_ready"},  32'(ins_ready_out),  32'(e.x_ir));
        chk({tag, " ins_data"},   ins_data_out,        e.x_id);
        chk({tag, " ins_err"},    32'(ins_err_out),    32'(e.x_ie));
        chk({tag, " data_ready"}, 32'(data_ready_out), 32'(e.x_dr));
        chk({tag, " data_rdata"}, data_rdata_out,      e.x_drd);
        chk({tag, " data_err"},   32'(data_err_out),   32'(e.x_de));
    endtask

    task automatic drive(input vec_t v);
        reset_in      = v.rst;
        ins_valid_in  = v.iv;
        ins_addr_in   = v.ia;
        data_valid_in = v.dv;
        data_write_in = v.dw;
        data_addr_in  = v.da;
        data_wdata_in = v.dwd;
        mem_ready_in  = v.mr;
        mem_rdata_in  = v.mrd;
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        vec_t v;
        int mv_cnt;
        bit seen;

        // Reset, single fetch with same-cycle ready, stray ready in IDLE, delayed store, stray ready in RESP
        tbl[0]  = '{rst: 1'b1, default: '0};
        tbl[1]  = '{iv: 1'b1, ia: 32'h10, x_mv: 1'b1, x_ma: 32'h10, default: '0};
        tbl[2]  = '{iv: 1'b1, ia: 32'h10, mr: 1'b1, mrd: 32'hDEADBEEF,
                    x_ma: 32'h10, x_ir: 1'b1, x_id: 32'hDEADBEEF, default: '0};
        tbl[3]  = '{x_ma: 32'h10, x_id: 32'hDEADBEEF, default: '0};
        tbl[4]  = '{mr: 1'b1, mrd: 32'h55555555, x_ma: 32'h10, x_id: 32'hDEADBEEF, default: '0};
        for (int i = 5; i <= 8; i++)
            tbl[i] = '{dv: 1'b1, dw: 1'b1, da: 32'h100, dwd: 32'h12345678,
                       x_mv: 1'b1, x_mw: 1'b1, x_ma: 32'h100, x_mwd: 32'h12345678,
                       x_id: 32'hDEADBEEF, default: '0};
        tbl[9]  = '{dv: 1'b1, dw: 1'b1, da: 32'h100, dwd: 32'h12345678, mr: 1'b1, mrd: 32'hAAAA0000,
                    x_mw: 1'b1, x_ma: 32'h100, x_mwd: 32'h12345678, x_id: 32'hDEADBEEF,
                    x_dr: 1'b1, x_drd: 32'hAAAA0000, default: '0};
        for (int i = 10; i <= 11; i++)
            tbl[i] = '{mr: 1'b1, mrd: 32'h77777777,
                       x_mw: 1'b1, x_ma: 32'h100, x_mwd: 32'h12345678, x_id: 32'hDEADBEEF,
                       x_drd: 32'hAAAA0000, default: '0};

        v = '{default: '0};
        drive(v);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            step();
            chk_all($sformatf("row%0d", i), tbl[i]);
        end

        // Contention from reset: ins, data, ins, data, one access every 3 cycles
        v = '{rst: 1'b1, default: '0};
        drive(v);
        step();
        v = '{iv: 1'b1, ia: 32'h20, dv: 1'b1, da: 32'h200, mr: 1'b1, mrd: 32'hC0DE0000, default: '0};
        drive(v);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("rr%0d mem_valid", k), 32'(mem_valid_out), 32'(k % 3 == 1));
            chk($sformatf("rr%0d ins_ready", k), 32'(ins_ready_out), 32'(k == 2 || k == 8));
            chk($sformatf("rr%0d data_ready", k), 32'(data_ready_out), 32'(k == 5 || k == 11));
            if (k % 3 == 1)
                chk($sformatf("rr%0d mem_addr", k), mem_addr_out, (k == 1 || k == 7) ? 32'h20 : 32'h200);
        end
        chk("rr ins_data", ins_data_out, 32'hC0DE0000);
        chk("rr data_rdata", data_rdata_out, 32'hC0DE0000);

        // Timeout on a data load (TIMEOUT=4), then a normal fetch
        v = '{default: '0};
        drive(v);
        step();
        step();
        v = '{dv: 1'b1, da: 32'h300, default: '0};
        drive(v);
        mv_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step();
            if (mem_valid_out) mv_cnt++;
            if (data_ready_out) seen = 1'b1;
        end
        chk("to data_ready seen", 32'(seen), 32'd1);
        chk("to mem_valid cycles", mv_cnt, 32'd4);
        chk("to data_err", 32'(data_err_out), 32'd1);
        chk("to data_rdata", data_rdata_out, 32'h0);
        chk("to ins_ready", 32'(ins_ready_out), 32'd0);
        v = '{default: '0};
        drive(v);
        step();
        chk("to err cleared", 32'(data_err_out), 32'd0);
        v = '{iv: 1'b1, ia: 32'h44, mr: 1'b1, mrd: 32'h13579BDF, default: '0};
        drive(v);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step();
            if (mem_valid_out) chk("to2 mem_addr", mem_addr_out, 32'h44);
            if (ins_ready_out) seen = 1'b1;
        end
        chk("to2 ins_ready seen", 32'(seen), 32'd1);
        chk("to2 ins_data", ins_data_out, 32'h13579BDF);
        chk("to2 ins_err", 32'(ins_err_out), 32'd0);
        chk("to2 data_ready", 32'(data_ready_out), 32'd0);

        // Reset in the second cycle of a pending store, late mem_ready afterwards
        v = '{default: '0};
        drive(v);
        step();
        v = '{dv: 1'b1, dw: 1'b1, da: 32'h500, dwd: 32'hFFFF0000, default: '0};
        drive(v);
        step();
        chk("rst acc mem_valid", 32'(mem_valid_out), 32'd1);
        step();
        v = '{rst: 1'b1, default: '0};
        drive(v);
        step();
        v = '{default: '0};
        chk_all("rst", v);
        v = '{mr: 1'b1, mrd: 32'h99999999, default: '0};
        drive(v);
        step();
        v = '{default: '0};
        chk_all("rst late", v);
        v = '{iv: 1'b1, ia: 32'h60, mr: 1'b1, mrd: 32'h2468ACE0, default: '0};
        drive(v);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step();
            if (data_ready_out) chk("rst2 stray data_ready", 32'(data_ready_out), 32'd0);
            if (ins_ready_out) seen = 1'b1;
        end
        chk("rst2 ins_ready seen", 32'(seen), 32'd1);
        chk("rst2 ins_data", ins_data_out, 32'h2468ACE0);
        chk("rst2 ins_err", 32'(ins_err_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
